// File: rtl/cpu_run_controller.sv
// Run/halt/step sequencer for the CPU core: debounced controls, selectable clock-enable
// rate, and a CPU reset held for a fixed number of enables.
module cpu_run_controller #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RESET_HOLD      = 8,
  parameter int CNT_W           = 32
) (
  input  logic             clock_in,
  input  logic             reset_n_in,
  input  logic             key_reset_n,
  input  logic             key_step_n,
  input  logic             sw_run,
  input  logic [3:0]       div_sel,
  output logic             cpu_ce,
  output logic             cpu_reset,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] ce_count
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(RESET_HOLD + 1);
  // Released levels, packed as {sw_run, key_step_n, key_reset_n}
  localparam logic [2:0] RELEASED = 3'b011;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_HALT = 2'd1,
    S_RUN  = 2'd2,
    S_STEP = 2'd3
  } state_t;

  logic [2:0]      pin;
  logic [2:0]      sync_p0, sync_p1, db_p2, db_p3;
  logic [DB_W-1:0] db_cnt [3];
  logic [1:0]      press_p3;
  logic            run_lvl, reset_press, step_press;

  logic [15:0]       div_p0, div_mask;
  logic              tick;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              ce_d, reset_d;
  logic [CNT_W-1:0]  count_d;

  assign pin = {sw_run, key_step_n, key_reset_n};

  // Stage p0/p1: synchronisers; p2: debounced level; p3: delayed level and press pulse
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      sync_p0  <= RELEASED;
      sync_p1  <= RELEASED;
      db_p2    <= RELEASED;
      db_p3    <= RELEASED;
      press_p3 <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0 <= pin;
      sync_p1 <= sync_p0;
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[i] == db_p2[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt[i] <= '0;
          db_p2[i]  <= sync_p1[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
      db_p3    <= db_p2;
      press_p3 <= db_p3[1:0] & ~db_p2[1:0];
    end
  end

  // Run level taken from p3 so it lines up with the press pulses
  assign run_lvl     = db_p3[2];
  assign reset_press = press_p3[0];
  assign step_press  = press_p3[1];

  // Tick when the low div_sel+1 bits of the free-running divider are all ones
  assign div_mask = ~(16'hFFFE << div_sel);
  assign tick     = (div_p0 & div_mask) == div_mask;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    count_d = ce_count;
    ce_d    = tick && (state_q != S_HALT);
    case (state_q)
      S_HOLD: begin
        // Leave one cycle after the last held tick so that enable still sees reset high
        if (hold_q == HOLD_W'(RESET_HOLD)) begin
          hold_d  = '0;
          state_d = run_lvl ? S_RUN : S_HALT;
        end else if (tick) begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_HALT: begin
        if (run_lvl)         state_d = S_RUN;
        else if (step_press) state_d = S_STEP;
      end
      S_STEP:  if (tick) state_d = S_HALT;
      S_RUN:   if (!run_lvl) state_d = S_HALT;
      default: state_d = S_HOLD;
    endcase
    if (ce_d && (state_q != S_HOLD)) count_d = ce_count + 1'b1;
    if (reset_press) begin
      state_d = S_HOLD;
      hold_d  = '0;
      count_d = '0;
    end
    reset_d = (state_d == S_HOLD);
  end

  // Stage p0: divider, FSM state and registered outputs
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      div_p0    <= '0;
      state_q   <= S_HOLD;
      hold_q    <= '0;
      cpu_ce    <= 1'b0;
      cpu_reset <= 1'b1;
      ce_count  <= '0;
    end else begin
      div_p0    <= div_p0 + 1'b1;
      state_q   <= state_d;
      hold_q    <= hold_d;
      cpu_ce    <= ce_d;
      cpu_reset <= reset_d;
      ce_count  <= count_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: timeline table of input changes and expected
// outputs at absolute clock edges since reset release, plus reset corner sequences.
module tb_cpu_run_controller;

  localparam int CNT_W = 4;

  logic             clock_in = 1'b0;
  logic             reset_n_in = 1'b0;
  logic             key_reset_n = 1'b1;
  logic             key_step_n = 1'b1;
  logic             sw_run = 1'b0;
  logic [3:0]       div_sel = 4'd1;
  logic             cpu_ce, cpu_reset;
  logic [1:0]       state;
  logic [CNT_W-1:0] ce_count;

  cpu_run_controller #(
    .DEBOUNCE_CYCLES(4),
    .RESET_HOLD     (2),
    .CNT_W          (CNT_W)
  ) dut (
    .clock_in   (clock_in),
    .reset_n_in (reset_n_in),
    .key_reset_n(key_reset_n),
    .key_step_n (key_step_n),
    .sw_run     (sw_run),
    .div_sel    (div_sel),
    .cpu_ce     (cpu_ce),
    .cpu_reset  (cpu_reset),
    .state      (state),
    .ce_count   (ce_count)
  );

  always #5 clock_in = ~clock_in;

  int cyc = 0;
  int ce_total = 0;
  int step_total = 0;
  int ce_base = 0;
  int step_base = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clock_in) begin
    if (!reset_n_in) cyc <= 0;
    else             cyc <= cyc + 1;
  end

  always @(negedge clock_in) begin
    if (cpu_ce) ce_total <= ce_total + 1;
    if (state == 2'd3) step_total <= step_total + 1;
  end

  typedef struct {
    int e;
    int run, stepn, rstn, div;
    int st, rst, cnt, ce, pul;
    int clr, nostep;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int e, input int run, input int stepn, input int rstn,
                              input int div, input int st, input int rst, input int cnt,
                              input int ce, input int pul, input int clr, input int nostep);
    vec_t v;
    v.e = e; v.run = run; v.stepn = stepn; v.rstn = rstn; v.div = div;
    v.st = st; v.rst = rst; v.cnt = cnt; v.ce = ce; v.pul = pul;
    v.clr = clr; v.nostep = nostep;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic to_edge(input int n);
    while (cyc < n) begin
      @(posedge clock_in);
      #1;
    end
  endtask

  initial begin
    // edge, run, step_n, reset_n, div | state, cpu_reset, ce_count, cpu_ce, pulses(-1 skip) | clr, nostep
    add(   3, 0, 1, 1,  1,  0, 1,  0, 0,  -1, 1, 0);
    add(   8, 0, 1, 1,  1,  0, 1,  0, 1,  -1, 0, 0);
    add(   9, 0, 1, 1,  1,  1, 0,  0, 0,  -1, 0, 0);
    add(  20, 0, 0, 1,  1,  1, 0,  0, 0,   2, 1, 0);
    add(  27, 0, 0, 1,  1,  1, 0,  0, 0,  -1, 0, 0);
    add(  28, 0, 0, 1,  1,  3, 0,  0, 0,  -1, 0, 0);
    add(  30, 0, 1, 1,  1,  3, 0,  0, 0,  -1, 0, 0);
    add(  32, 0, 1, 1,  1,  1, 0,  1, 1,  -1, 0, 0);
    add(  50, 0, 0, 1,  1,  1, 0,  1, 0,   1, 1, 0);
    add(  52, 0, 1, 1,  1,  1, 0,  1, 0,  -1, 0, 0);
    add(  70, 1, 1, 1,  1,  1, 0,  1, 0,   0, 1, 0);
    add(  77, 1, 1, 1,  1,  1, 0,  1, 0,  -1, 0, 0);
    add(  78, 1, 1, 1,  1,  2, 0,  1, 0,  -1, 0, 0);
    add(  80, 1, 1, 1,  1,  2, 0,  2, 1,  -1, 1, 0);
    add( 120, 1, 1, 1,  3,  2, 0, 12, 1,  10, 0, 0);
    add( 121, 1, 1, 1,  3,  2, 0, 12, 0,  -1, 1, 0);
    add(1721, 1, 1, 1,  1,  2, 0,  0, 0, 100, 0, 0);
    add(1724, 1, 1, 1,  1,  2, 0,  1, 1,  -1, 0, 0);
    add(1730, 1, 1, 0,  1,  2, 0,  2, 0,  -1, 0, 0);
    add(1737, 1, 1, 0,  1,  2, 0,  4, 0,  -1, 0, 0);
    add(1738, 1, 1, 0,  1,  0, 1,  0, 0,  -1, 0, 0);
    add(1740, 1, 1, 1,  1,  0, 1,  0, 1,  -1, 1, 0);
    add(1744, 1, 1, 1,  1,  0, 1,  0, 1,  -1, 0, 0);
    add(1745, 1, 1, 1,  1,  2, 0,  0, 0,   2, 0, 0);
    add(1748, 1, 1, 1,  1,  2, 0,  1, 1,  -1, 0, 0);
    add(1811, 1, 1, 1,  1,  2, 0,  0, 0,  -1, 0, 0);
    add(1812, 1, 1, 1,  1,  2, 0,  1, 1,  -1, 0, 0);
    add(1820, 0, 1, 1,  1,  2, 0,  3, 1,  -1, 0, 0);
    add(1828, 0, 1, 1,  1,  1, 0,  5, 1,  -1, 0, 0);
    add(1840, 1, 0, 1,  1,  1, 0,  5, 0,  -1, 1, 0);
    add(1847, 1, 0, 1,  1,  1, 0,  5, 0,  -1, 0, 0);
    add(1848, 1, 0, 1,  1,  2, 0,  5, 0,  -1, 0, 0);
    add(1850, 1, 1, 1,  1,  2, 0,  5, 0,  -1, 0, 0);
    add(1860, 0, 1, 1,  1,  2, 0,  8, 1,  -1, 0, 1);
    add(1868, 0, 1, 1, 15,  1, 0, 10, 1,  -1, 0, 0);
    add(1870, 0, 0, 1, 15,  1, 0, 10, 0,  -1, 0, 0);
    add(1878, 0, 0, 1, 15,  3, 0, 10, 0,  -1, 0, 0);

    repeat (3) @(posedge clock_in);
    #1;
    check("reset_state", int'(state), 0);
    check("reset_cpu_reset", int'(cpu_reset), 1);
    check("reset_cpu_ce", int'(cpu_ce), 0);
    check("reset_ce_count", int'(ce_count), 0);
    reset_n_in = 1'b1;

    foreach (tbl[i]) begin
      to_edge(tbl[i].e);
      check("state", int'(state), tbl[i].st);
      check("cpu_reset", int'(cpu_reset), tbl[i].rst);
      check("ce_count", int'(ce_count), tbl[i].cnt);
      check("cpu_ce", int'(cpu_ce), tbl[i].ce);
      if (tbl[i].pul >= 0) check("pulses", ce_total - ce_base, tbl[i].pul);
      if (tbl[i].nostep != 0) check("no_step_entered", step_total - step_base, 0);
      sw_run      = tbl[i].run[0];
      key_step_n  = tbl[i].stepn[0];
      key_reset_n = tbl[i].rstn[0];
      div_sel     = tbl[i].div[3:0];
      if (tbl[i].clr != 0) begin
        ce_base   = ce_total;
        step_base = step_total;
      end
    end

    // Asynchronous reset while a step is waiting for a very distant tick
    to_edge(1880);
    check("step_pending_state", int'(state), 3);
    #2;
    reset_n_in = 1'b0;
    key_step_n = 1'b1;
    div_sel    = 4'd1;
    #1;
    check("async_state", int'(state), 0);
    check("async_cpu_reset", int'(cpu_reset), 1);
    check("async_cpu_ce", int'(cpu_ce), 0);
    check("async_ce_count", int'(ce_count), 0);

    // Restart from reset: two held enables, then halt with no leftover press
    repeat (3) @(posedge clock_in);
    #1;
    reset_n_in = 1'b1;
    ce_base = ce_total;
    to_edge(20);
    check("restart_state", int'(state), 1);
    check("restart_cpu_reset", int'(cpu_reset), 0);
    check("restart_ce_count", int'(ce_count), 0);
    check("restart_pulses", ce_total - ce_base, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
